// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns a simple valid/ready command stream into single AHB
// transfers (SINGLE bursts only), overlapping the next address phase with the
// current data phase and returning one response pulse per completed transfer.
// Optional feature: define AHB_MST_ERR_RETRY_EN to withdraw a pending address
// phase on an ERROR response, reissue it afterwards, and report rsp_err.
module ahb_cmd_master (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        hsel,
    output logic        hwrite,
    output logic        hready,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    input  logic        hready_resp,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata,
    output logic        busy
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Sizes above word are clamped to word.
    function automatic logic [2:0] eff_size(input logic [2:0] size);
        if (size > 3'd2) begin
            eff_size = 3'b010;
        end else begin
            eff_size = size;
        end
    endfunction

    // Clear the low address bits that the transfer size requires to be zero.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] size);
        case (size)
            3'b000:  align_addr = addr;
            3'b001:  align_addr = {addr[31:1], 1'b0};
            default: align_addr = {addr[31:2], 2'b00};
        endcase
    endfunction

    // Address slot, data slot and registered AHB / response outputs
    logic        addr_vld_q,   addr_vld_d;
    logic        data_vld_q,   data_vld_d;
    logic [31:0] haddr_q,      haddr_d;
    logic        hwrite_q,     hwrite_d;
    logic [2:0]  hsize_q,      hsize_d;
    logic [31:0] addr_wdata_q, addr_wdata_d;
    logic        data_write_q, data_write_d;
    logic [31:0] hwdata_q,     hwdata_d;
    logic [1:0]  htrans_q,     htrans_d;
    logic        hsel_q,       hsel_d;
    logic        rsp_valid_q,  rsp_valid_d;
    logic        rsp_write_q,  rsp_write_d;
    logic        rsp_err_q,    rsp_err_d;
    logic [31:0] rsp_rdata_q,  rsp_rdata_d;
    logic        busy_q,       busy_d;

    logic        withdrawn_s;     // address phase currently withdrawn after an error
    logic        withdrawn_nx_s;  // value of that flag after the coming edge
    logic        err_first_s;     // first cycle of a two-cycle ERROR response
    logic        err_done_s;      // data phase completes with ERROR
    logic        cmd_ready_s;
    logic        accept_s;
    logic        addr_done_s;
    logic        data_done_s;

`ifdef AHB_MST_ERR_RETRY_EN
    logic        withdrawn_q, withdrawn_d;

    // Error-retry decode: detect the ERROR response and track withdrawal
    always_comb begin
        withdrawn_s = withdrawn_q;
        err_first_s = data_vld_q && !hready_resp && (hresp == HRESP_ERROR);
        err_done_s  = data_vld_q && hready_resp && (hresp == HRESP_ERROR);
        withdrawn_d = withdrawn_q;
        if (err_first_s) begin
            // Whatever sits in the address slot after this edge must go idle.
            withdrawn_d = addr_vld_d;
        end else if (hready_resp) begin
            withdrawn_d = 1'b0;
        end else begin
            withdrawn_d = withdrawn_q;
        end
        withdrawn_nx_s = withdrawn_d;
    end

    // Withdrawal flag register
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            withdrawn_q <= 1'b0;
        end else begin
            withdrawn_q <= withdrawn_d;
        end
    end
`else
    logic unused_hresp_s;
    assign unused_hresp_s = ^hresp;

    // Without error retry the response code has no effect
    always_comb begin
        withdrawn_s    = 1'b0;
        withdrawn_nx_s = 1'b0;
        err_first_s    = 1'b0;
        err_done_s     = 1'b0;
    end
`endif

    // Handshake and phase-completion decode
    always_comb begin
        cmd_ready_s = !addr_vld_q || (hready_resp && !withdrawn_s);
        accept_s    = cmd_valid && cmd_ready_s;
        addr_done_s = addr_vld_q && hready_resp && !withdrawn_s;
        data_done_s = data_vld_q && hready_resp;
    end

    // Next-state logic for both slots, AHB outputs and the response
    always_comb begin
        addr_vld_d   = addr_vld_q;
        data_vld_d   = data_vld_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        addr_wdata_d = addr_wdata_q;
        data_write_d = data_write_q;
        hwdata_d     = hwdata_q;
        rsp_valid_d  = 1'b0;
        rsp_write_d  = rsp_write_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;

        // Address phase done: command moves into the data slot.
        if (addr_done_s) begin
            data_vld_d   = 1'b1;
            data_write_d = hwrite_q;
            if (hwrite_q) begin
                hwdata_d = addr_wdata_q;
            end else begin
                hwdata_d = hwdata_q;
            end
        end else if (data_done_s) begin
            data_vld_d = 1'b0;
        end else begin
            data_vld_d = data_vld_q;
        end

        // Accepted command fills the address slot; otherwise outputs hold.
        if (accept_s) begin
            addr_vld_d   = 1'b1;
            haddr_d      = align_addr(cmd_addr, cmd_size);
            hsize_d      = eff_size(cmd_size);
            hwrite_d     = cmd_write;
            addr_wdata_d = cmd_wdata;
        end else if (addr_done_s) begin
            addr_vld_d = 1'b0;
        end else begin
            addr_vld_d = addr_vld_q;
        end

        // Data phase done: one-cycle response pulse.
        if (data_done_s) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = data_write_q;
            rsp_err_d   = err_done_s;
            if (!data_write_q) begin
                rsp_rdata_d = hrdata;
            end else begin
                rsp_rdata_d = rsp_rdata_q;
            end
        end else begin
            rsp_valid_d = 1'b0;
        end

        if (addr_vld_d && !withdrawn_nx_s) begin
            htrans_d = HTRANS_NONSEQ;
        end else begin
            htrans_d = HTRANS_IDLE;
        end
        hsel_d = addr_vld_d;
        busy_d = addr_vld_d || data_vld_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            addr_vld_q   <= 1'b0;
            data_vld_q   <= 1'b0;
            haddr_q      <= 32'h0000_0000;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'b000;
            addr_wdata_q <= 32'h0000_0000;
            data_write_q <= 1'b0;
            hwdata_q     <= 32'h0000_0000;
            htrans_q     <= HTRANS_IDLE;
            hsel_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            busy_q       <= 1'b0;
        end else begin
            addr_vld_q   <= addr_vld_d;
            data_vld_q   <= data_vld_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            addr_wdata_q <= addr_wdata_d;
            data_write_q <= data_write_d;
            hwdata_q     <= hwdata_d;
            htrans_q     <= htrans_d;
            hsel_q       <= hsel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_write_q  <= rsp_write_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign hready    = hready_resp;
    assign hburst    = 3'b000;
    assign htrans    = htrans_q;
    assign hsel      = hsel_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule
